mux8_rr_arbiter: RTL and testbench

Round-robin controller that shares the 8:1 single-bit multiplexer between eight requesters. It arbitrates `req[7:0]`, registers a one-hot grant and the matching 3-bit select, and drives the gated mux output `y`. A per-grant hold limit bounds how long one requester can keep the channel. It sits directly in front of the 8:1 mux datapath: `sel[0]`/`sel[1]`/`sel[2]` map to S0/S1/S2 and `d[i]` maps to Ii.

---
 rtl/mux8_rr_arbiter.sv | 110 +++++++++++
 tb/tb_mux8_rr_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing an 8:1 single-bit mux among eight requesters,
// with a per-grant hold limit. Optional hold-override input under MUX8_ARB_LOCK_EN.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] d,
`ifdef MUX8_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       valid,
  output logic       y
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_nx;
  logic [2:0] cur, cur_nx, ptr, ptr_nx, sel_nx;
  logic [7:0] cnt, cnt_nx, gnt_nx;
  logic       valid_nx;

  logic       lk, at_limit, rel, found;
  logic [7:0] cand;
  logic [2:0] win, idx;

`ifdef MUX8_ARB_LOCK_EN
  assign lk = lock;
`else
  assign lk = 1'b0;
`endif

  assign at_limit = (cnt == HOLD_LAST);
  assign rel      = !req[cur] || (at_limit && !lk);

  // A holder that dropped its request is excluded; one that merely expired
  // stays eligible and, scanning from cur+1, only re-wins if nobody else asks.
  always_comb begin
    cand  = req;
    if (state == GRANT && !req[cur]) cand[cur] = 1'b0;
    found = 1'b0;
    win   = 3'd0;
    idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    gnt_nx   = gnt;
    sel_nx   = sel;
    valid_nx = valid;
    if (state == IDLE || rel) begin
      if (found) begin
        state_nx = GRANT;
        cur_nx   = win;
        gnt_nx   = 8'b1 << win;
        sel_nx   = win;
        valid_nx = 1'b1;
        cnt_nx   = 8'd0;
        ptr_nx   = win + 3'd1;
      end else begin
        state_nx = IDLE;
        gnt_nx   = 8'd0;
        sel_nx   = 3'd0;
        valid_nx = 1'b0;
        cnt_nx   = 8'd0;
      end
    end else begin
      // Saturates only while locked; otherwise rel fires at the limit.
      cnt_nx = at_limit ? cnt : cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur   <= 3'd0;
      ptr   <= 3'd0;
      cnt   <= 8'd0;
      gnt   <= 8'd0;
      sel   <= 3'd0;
      valid <= 1'b0;
    end else begin
      state <= state_nx;
      cur   <= cur_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
      gnt   <= gnt_nx;
      sel   <= sel_nx;
      valid <= valid_nx;
    end
  end

  assign y = valid & d[sel];

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed and randomized bench for mux8_rr_arbiter, using a small
// integer-based reference model of the round-robin/hold rules.
module tb_mux8_rr_arbiter;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] d   = 8'h00;
  logic       lock = 1'b0;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid, y;

  int checks = 0;
  int errors = 0;

  // reference state: m_cur = -1 means no grant
  int m_cur = -1;
  int m_cnt = 0;
  int m_ptr = 0;

  mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .d    (d),
`ifdef MUX8_ARB_LOCK_EN
    .lock (lock),
`endif
    .gnt  (gnt),
    .sel  (sel),
    .valid(valid),
    .y    (y)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++)
      if (r[(start + k) % 8]) return (start + k) % 8;
    return -1;
  endfunction

  task automatic model_edge();
    logic [7:0] cand;
    int w;
    bit rel;
    if (rst) begin
      m_cur = -1; m_cnt = 0; m_ptr = 0;
    end else begin
      cand = req;
      if (m_cur < 0) rel = 1'b1;
      else begin
        rel = !req[m_cur] || (m_cnt == MAX_HOLD - 1 && !lock);
        if (!req[m_cur]) cand[m_cur] = 1'b0;
      end
      if (!rel) begin
        if (m_cnt < MAX_HOLD - 1) m_cnt++;
      end else begin
        w = pick(cand, m_ptr);
        if (w >= 0) begin
          m_cur = w; m_cnt = 0; m_ptr = (w + 1) % 8;
        end else begin
          m_cur = -1; m_cnt = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_model(input string tag);
    logic [7:0] eg;
    logic [2:0] es;
    logic       ev;
    eg = (m_cur < 0) ? 8'h00 : (8'h01 << m_cur);
    es = (m_cur < 0) ? 3'd0 : 3'(m_cur);
    ev = (m_cur >= 0);
    chk({tag, ".gnt"},   32'(gnt),   32'(eg));
    chk({tag, ".sel"},   32'(sel),   32'(es));
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    chk({tag, ".y"},     32'(y),     32'(ev & d[es]));
  endtask

  initial begin
    // reset with everyone requesting
    rst = 1'b1; req = 8'hFF; d = 8'hFF;
    step(); step();
    chk("rst.gnt", 32'(gnt), 32'h00);
    chk("rst.sel", 32'(sel), 32'h0);
    chk("rst.valid", 32'(valid), 32'h0);
    chk("rst.y", 32'(y), 32'h0);
    rst = 1'b0;
    step();
    chk("first.gnt", 32'(gnt), 32'h01);
    req = 8'h00;
    step();
    chk("drain.valid", 32'(valid), 32'h0);

    // single requester, combinational y, hold re-win
    req = 8'h20; d = 8'h20;
    step();
    chk("single.gnt", 32'(gnt), 32'h20);
    chk("single.sel", 32'(sel), 32'h5);
    chk("single.y1", 32'(y), 32'h1);
    d = 8'h00; #1;
    chk("single.y0", 32'(y), 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("single.hold", 32'(gnt), 32'h20);
    end

    // rotation under full contention
    rst = 1'b1; req = 8'h00; step(); rst = 1'b0;
    req = 8'hFF;
    for (int n = 0; n < 8 * MAX_HOLD + MAX_HOLD; n++) begin
      step();
      chk("rot.sel", 32'(sel), 32'((n / MAX_HOLD) % 8));
      chk("rot.valid", 32'(valid), 32'h1);
    end

    // early drop then idle
    rst = 1'b1; step(); rst = 1'b0;
    req = 8'h81;
    step();
    chk("drop.g0", 32'(gnt), 32'h01);
    step();
    req = 8'h80;
    step();
    chk("drop.g7", 32'(gnt), 32'h80);
    req = 8'h00;
    step();
    chk("drop.idle", 32'(valid), 32'h0);

`ifdef MUX8_ARB_LOCK_EN
    req = 8'h03; lock = 1'b1;
    step();
    chk("lock.g0", 32'(gnt), 32'h01);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("lock.hold", 32'(gnt), 32'h01);
    end
    lock = 1'b0;
    step();
    chk("lock.rel", 32'(gnt), 32'h02);
    req = 8'h00; step();
`endif

    // reset mid-grant
    rst = 1'b1; step(); rst = 1'b0;
    req = 8'h18;
    step();
    chk("midrst.g3", 32'(gnt), 32'h08);
    step();
    rst = 1'b1;
    step();
    chk("midrst.gnt", 32'(gnt), 32'h00);
    chk("midrst.valid", 32'(valid), 32'h0);
    rst = 1'b0;
    step();
    chk("midrst.again", 32'(gnt), 32'h08);

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: req = 8'($urandom);
        1: req = 8'h01 << $urandom_range(0, 7);
        2: req = 8'($urandom) & 8'($urandom);
        default: ;
      endcase
      d    = 8'($urandom);
      rst  = ($urandom_range(0, 59) == 0);
`ifdef MUX8_ARB_LOCK_EN
      lock = ($urandom_range(0, 3) == 0);
`endif
      step();
      chk_model("rand");
      d = 8'($urandom); #1;
      chk_model("rand_d");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
